// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/NZCV flags and a multi-cycle shift-add multiply
module alu_seq #(
    parameter int WIDTH  = 64,
    parameter int MUL_EN = 1
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [3:0]       ALUCtrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] BusW,
    output logic             Zero,
    output logic             Neg,
    output logic             Carry,
    output logic             Ovf,
    output logic             Illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [3:0] OP_AND = 4'b0000, OP_ORR = 4'b0001, OP_ADD = 4'b0010, OP_LSL = 4'b0011,
                           OP_LSR = 4'b0100, OP_SUB = 4'b0110, OP_PASSB = 4'b0111, OP_MUL = 4'b1000;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt, res;
    logic [SHW-1:0] cnt;
    logic [WIDTH:0] sum, dif;
    logic c, v, ill, is_mul, mul_last;
    always_comb begin
        sum = {1'b0, BusA} + {1'b0, BusB};
        dif = {1'b0, BusA} + {1'b0, ~BusB} + (WIDTH+1)'(1);
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        case (ALUCtrl)
            OP_AND:   res = BusA & BusB;
            OP_ORR:   res = BusA | BusB;
            OP_ADD: begin
                {c, res} = sum;
                v = (BusA[MSB] == BusB[MSB]) && (res[MSB] != BusA[MSB]);
            end
            OP_SUB: begin
                {c, res} = dif;
                v = (BusA[MSB] != BusB[MSB]) && (res[MSB] != BusA[MSB]);
            end
            OP_LSL:   res = BusA << BusB[SHW-1:0];
            OP_LSR:   res = BusA >> BusB[SHW-1:0];
            OP_PASSB: res = BusB;
            OP_MUL:   ill = (MUL_EN == 0);
            default:  ill = 1'b1;
        endcase
        is_mul   = (ALUCtrl == OP_MUL) && (MUL_EN != 0);
        acc_nxt  = mplier[0] ? acc + mcand : acc;
        mul_last = (cnt == SHW'(WIDTH - 1));
    end
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid) state_nxt = is_mul ? MUL : DONE;
            MUL:     if (mul_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!resetl) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            BusW    <= '0;
            Zero    <= 1'b0;
            Neg     <= 1'b0;
            Carry   <= 1'b0;
            Ovf     <= 1'b0;
            Illegal <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else if (state == IDLE && in_valid) begin
            if (is_mul) begin
                mcand  <= BusA;
                mplier <= BusB;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                BusW    <= res;
                Zero    <= (res == '0);
                Neg     <= res[MSB];
                Carry   <= c;
                Ovf     <= v;
                Illegal <= ill;
            end
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            // final iteration publishes the low WIDTH bits of the product directly
            if (mul_last) begin
                BusW    <= acc_nxt;
                Zero    <= (acc_nxt == '0);
                Neg     <= acc_nxt[MSB];
                Carry   <= 1'b0;
                Ovf     <= 1'b0;
                Illegal <= 1'b0;
            end
        end
    end
endmodule
